// File: rtl/snn_soc_pkg.sv
// Shared SoC-level constants and helpers for the spike event path.
// The round-robin index helper is reused by every arbiter in the SoC.
package snn_soc_pkg;

    localparam int OUTPUT_FIFO_DEPTH = 16;
    localparam int SPIKE_ID_W        = 4;
    localparam int NUM_SPIKE_SRC     = 4;

    // last_idx + offset is at most 2*num-1, so one conditional subtract is a full modulo.
    function automatic int rr_next_idx(input int last_idx, input int offset, input int num);
        int sum;
        sum = last_idx + offset;
        return (sum >= num) ? sum - num : sum;
    endfunction

endpackage

// File: rtl/evt_fifo_push_arb_if.sv
// Requester handshake plus FIFO push-side bus shared by the event arbiter.
// master = arbiter side, slave = requesters/FIFO side.
interface evt_fifo_push_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       fifo_push;
    logic [WIDTH-1:0]           fifo_push_data;
    logic                       fifo_full;
    logic                       fifo_pop;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       fifo_overflow;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_pop, fifo_count, fifo_overflow,
        output req_ready, fifo_push, fifo_push_data
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_pop, fifo_count, fifo_overflow,
        input  req_ready, fifo_push, fifo_push_data
    );
endinterface

// File: rtl/evt_fifo_push_arb_rr_arbiter_core.sv
// Purely combinational round-robin pick: scans upward from last+1, wrapping modulo N.
module rr_arbiter_core
    import snn_soc_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);
    localparam int CAND_W = IDX_W + 1;

    logic [CAND_W-1:0] cand;
    logic [N-1:0]      req_rot;
    logic              found;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt_oh  = '0;
        winner  = last;
        found   = 1'b0;
        cand    = '0;
        req_rot = '0;
        for (int k = 1; k <= N; k++) begin
            cand    = CAND_W'(rr_next_idx(int'(last), k, N));
            req_rot = req >> cand;
            if (!found && req_rot[0]) begin
                found  = 1'b1;
                gnt_oh = N'(1) << cand;
                winner = IDX_W'(cand);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/evt_fifo_push_arb.sv
// Round-robin sharing of one FIFO push port between NUM_REQ event producers,
// with almost-full flag, saturating stall counter and sticky overflow latch.
module evt_fifo_push_arb
    import snn_soc_pkg::*;
#(
    parameter int NUM_REQ      = NUM_SPIKE_SRC,
    parameter int WIDTH        = SPIKE_ID_W,
    parameter int DEPTH        = OUTPUT_FIFO_DEPTH,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clr_stat,
    evt_fifo_push_arb_if.master        bus,
    output logic                       afull,
    output logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic                       ovf_sticky
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int FC_W  = $clog2(DEPTH + 1);
    localparam logic [FC_W-1:0]  AFULL_LVL = FC_W'(AFULL_THRESH);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || AFULL_THRESH > DEPTH) begin : g_bad_cfg
        $fatal(1, "evt_fifo_push_arb: NUM_REQ must be >= 2 and AFULL_THRESH <= DEPTH");
    end

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               space;
    logic               gnt;

    rr_arbiter_core #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_core (
        .req     (bus.req_valid),
        .last    (last_grant),
        .gnt_oh  (gnt_oh),
        .winner  (winner),
        .any_req (any_req)
    );

    // A same-cycle pop frees a slot, so a full FIFO can still take a push.
    assign space = !bus.fifo_full || bus.fifo_pop;
    assign gnt   = enable && space && rst_n && any_req;

    assign bus.req_ready = gnt ? gnt_oh : '0;
    assign bus.fifo_push = gnt;

    always_comb begin
        bus.fifo_push_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.fifo_push_data = bus.fifo_push_data |
                                 ({WIDTH{gnt_oh[i]}} & bus.req_data[i*WIDTH +: WIDTH]);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // reset is synchronous, so rst_n only acts at a clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= LAST_RST;
            afull      <= 1'b0;
            stall_cnt  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (gnt) begin
                last_grant <= winner;
            end
            afull <= (bus.fifo_count >= AFULL_LVL);
            if (clr_stat) begin
                stall_cnt <= '0;
            end else if (any_req && !gnt && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.fifo_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (clr_stat) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge clk) $onehot0(bus.req_ready));
    a_push_has_space: assert property (@(posedge clk) bus.fifo_push |-> (!bus.fifo_full || bus.fifo_pop));
`endif

endmodule
